// File: rtl/updown_gray_counter.sv
// Up/down counter with a programmable top value, wrap or saturate at the bounds,
// and a Gray-coded or plain binary output.
module updown_gray_counter #(
    parameter int WIDTH  = 3,
    parameter int MAXVAL = 2**WIDTH - 1,
    parameter bit GRAY   = 1'b1,
    parameter bit SAT    = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             A,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] Y,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAXVAL);

    logic [WIDTH-1:0] cnt;
    logic             at_max;
    logic             at_zero;

    // The bounds are compared explicitly, so a MAXVAL below 2**WIDTH-1 never
    // relies on the natural roll-over of the adder.
    assign at_max  = (cnt == MAX);
    assign at_zero = (cnt == '0);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of cnt regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            cnt  <= (d > MAX) ? MAX : d;
            wrap <= 1'b0;
        end else if (en) begin
            if (A) begin
                if (at_max) begin
                    cnt  <= SAT ? MAX : '0;
                    wrap <= 1'b1;
                end else begin
                    cnt  <= cnt + WIDTH'(1);
                    wrap <= 1'b0;
                end
            end else begin
                if (at_zero) begin
                    cnt  <= SAT ? '0 : MAX;
                    wrap <= 1'b1;
                end else begin
                    cnt  <= cnt - WIDTH'(1);
                    wrap <= 1'b0;
                end
            end
        end else begin
            wrap <= 1'b0;
        end
    end

    // Output encoding is a pure function of cnt, so Y adds no latency.
    assign Y  = GRAY ? (cnt ^ (cnt >> 1)) : cnt;
    assign tc = A ? at_max : at_zero;

endmodule

// File: tb/tb_updown_gray_counter.sv
// Directed bench for updown_gray_counter: default wrap/Gray, saturating Gray,
// and MAXVAL=5 binary instances driven from one shared stimulus stream.
module tb_updown_gray_counter;

    logic       clk = 1'b0;
    logic       reset, en, A, load;
    logic [2:0] d;
    logic [2:0] y0, y1, y2;
    logic       tc0, tc1, tc2;
    logic       wrap0, wrap1, wrap2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    updown_gray_counter u_def (
        .clk(clk), .reset(reset), .en(en), .A(A), .load(load), .d(d),
        .Y(y0), .tc(tc0), .wrap(wrap0)
    );

    updown_gray_counter #(.SAT(1'b1)) u_sat (
        .clk(clk), .reset(reset), .en(en), .A(A), .load(load), .d(d),
        .Y(y1), .tc(tc1), .wrap(wrap1)
    );

    updown_gray_counter #(.MAXVAL(5), .GRAY(1'b0)) u_bin5 (
        .clk(clk), .reset(reset), .en(en), .A(A), .load(load), .d(d),
        .Y(y2), .tc(tc2), .wrap(wrap2)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed results of ten up-steps from cnt=0.
    logic [2:0] up_y0  [10] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111,
                                3'b101, 3'b100, 3'b000, 3'b001, 3'b011};
    logic       up_w0  [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    logic [2:0] up_y1  [10] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111,
                                3'b101, 3'b100, 3'b100, 3'b100, 3'b100};
    logic       up_w1  [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    logic [2:0] up_y2  [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
                                3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    logic       up_w2  [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

    initial begin
        reset = 1'b1; en = 1'b1; A = 1'b1; load = 1'b1; d = 3'd6;

        // Reset overrides load and en.
        tick();
        check("rst_y0", y0, 3'b000);
        check("rst_wrap0", wrap0, 1'b0);
        check("rst_y2", y2, 3'd0);
        check("rst_tc_up", tc0, 1'b0);
        A = 1'b0; #1;
        check("rst_tc_down", tc0, 1'b1);

        // Ten up-steps: full Gray sequence, wrap, saturation, MAXVAL=5 roll-over.
        reset = 1'b0; load = 1'b0; en = 1'b1; A = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("up_y0[%0d]", i), y0, up_y0[i]);
            check($sformatf("up_w0[%0d]", i), wrap0, up_w0[i]);
            check($sformatf("up_y1[%0d]", i), y1, up_y1[i]);
            check($sformatf("up_w1[%0d]", i), wrap1, up_w1[i]);
            check($sformatf("up_y2[%0d]", i), y2, up_y2[i]);
            check($sformatf("up_w2[%0d]", i), wrap2, up_w2[i]);
            if (i == 6) check("tc0_at_max", tc0, 1'b1);
            if (i == 7) check("tc0_after_wrap", tc0, 1'b0);
        end

        // Saturated counter leaves the top bound once direction flips.
        A = 1'b0;
        tick();
        check("sat_down_y1", y1, 3'b101);
        check("sat_down_w1", wrap1, 1'b0);
        check("def_down_y0", y0, 3'b001);

        // Down from zero: wrap to MAXVAL, or hold at zero when saturating.
        reset = 1'b1;
        tick();
        reset = 1'b0; en = 1'b1; A = 1'b0;
        tick();
        check("dn0_y0", y0, 3'b100);
        check("dn0_w0", wrap0, 1'b1);
        check("dn0_y1", y1, 3'b000);
        check("dn0_w1", wrap1, 1'b1);
        check("dn0_y2", y2, 3'd5);
        check("dn0_w2", wrap2, 1'b1);
        tick();
        check("dn1_y0", y0, 3'b101);
        check("dn1_w0", wrap0, 1'b0);
        check("dn1_w1_held", wrap1, 1'b1);
        check("dn1_y2", y2, 3'd4);

        // Load beats en and clears wrap.
        load = 1'b1; d = 3'd2; en = 1'b1; A = 1'b1;
        tick();
        check("ld_y0", y0, 3'b011);
        check("ld_w1", wrap1, 1'b0);
        check("ld_y2", y2, 3'd2);

        // Reset mid-count: no partial step, resumes from zero.
        d = 3'd3;
        tick();
        load = 1'b0;
        tick();
        check("pre_rst_y2", y2, 3'd4);
        reset = 1'b1;
        tick();
        check("mid_rst_y2", y2, 3'd0);
        check("mid_rst_w0", wrap0, 1'b0);
        reset = 1'b0;
        tick();
        check("post_rst_y0", y0, 3'b001);
        check("post_rst_y2", y2, 3'd1);

        // Load above MAXVAL clamps.
        load = 1'b1; d = 3'd7;
        tick();
        check("clamp_y2", y2, 3'd5);
        check("clamp_y0", y0, 3'b100);

        // Hold with A toggling: output frozen, tc follows A.
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            A = i[0]; #1;
            check($sformatf("hold_tc0[%0d]", i), tc0, i[0]);
            check($sformatf("hold_tc2[%0d]", i), tc2, i[0]);
            tick();
            check($sformatf("hold_y0[%0d]", i), y0, 3'b100);
            check($sformatf("hold_w0[%0d]", i), wrap0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/updown_gray_counter.md
UPDOWN_GRAY_COUNTER -- requirements
Module: updown_gray_counter

Interface
REQ-001 Parameter WIDTH, default 3, count/output width in bits (2..16).
REQ-002 Parameter MAXVAL, default 2**WIDTH-1, highest count value (1..2**WIDTH-1); count range 0..MAXVAL.
REQ-003 Parameter GRAY, default 1, output encoding: 1 = Gray code of count, 0 = plain binary.
REQ-004 Parameter SAT, default 0, boundary mode: 0 = wrap-around, 1 = saturate at bounds.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 en  input  1  count enable; count steps once per clock while high.
REQ-008 A  input  1  direction: 1 = up, 0 = down.
REQ-009 load  input  1  synchronous parallel load strobe.
REQ-010 d  input  WIDTH  load value.
REQ-011 Y  output  WIDTH  encoded count (Gray or binary per GRAY).
REQ-012 tc  output  1  terminal count, combinational from state and A.
REQ-013 wrap  output  1  registered one-cycle pulse after a boundary event.

Function
REQ-014 Internal state SHALL be a WIDTH-bit binary register cnt; Y SHALL be cnt ^ (cnt >> 1) when GRAY=1, else cnt; Y is a pure function of cnt (no extra latency).
REQ-015 Per-edge priority SHALL be: reset > load > en > hold.
REQ-016 load=1: cnt <= d if d <= MAXVAL, else cnt <= MAXVAL (clamp); en and A ignored that cycle; wrap <= 0.
REQ-017 load=0, en=1, A=1, cnt < MAXVAL: cnt <= cnt+1; wrap <= 0.
REQ-018 load=0, en=1, A=0, cnt > 0: cnt <= cnt-1; wrap <= 0.
REQ-019 Up at cnt == MAXVAL: SAT=0 -> cnt <= 0; SAT=1 -> cnt holds MAXVAL; either mode wrap <= 1.
REQ-020 Down at cnt == 0: SAT=0 -> cnt <= MAXVAL; SAT=1 -> cnt holds 0; either mode wrap <= 1.
REQ-021 en=0 and load=0: cnt holds; wrap <= 0.
REQ-022 tc SHALL be 1 when (A=1 and cnt==MAXVAL) or (A=0 and cnt==0), independent of en; else 0.
REQ-023 A changing between edges SHALL affect only tc combinationally and the next step direction; no glitch-free guarantee on tc.
REQ-024 wrap SHALL be high exactly one cycle per boundary event; consecutive boundary steps (SAT=1 held at bound with en=1) SHALL keep wrap high on each such cycle.
REQ-025 Arithmetic SHALL be performed at WIDTH bits with explicit bound compare; no reliance on natural 2**WIDTH overflow when MAXVAL < 2**WIDTH-1.

Reset
REQ-026 reset=1 at a rising edge SHALL set cnt=0 (Y=0) and wrap=0, overriding load and en.
REQ-027 Reset asserted mid-count SHALL take effect at the next edge with no partial step; counting resumes from 0 the edge after reset deasserts.
REQ-028 tc after reset SHALL equal 1 if A=0, 0 if A=1.

Verification (defaults WIDTH=3, MAXVAL=7, GRAY=1, SAT=0 unless stated)
REQ-029 reset pulse, then en=1, A=1 for 8 edges -> Y = 000,001,011,010,110,111,101,100, then 000 with wrap=1 for one cycle; tc=1 while Y=100 (cnt=7).
REQ-030 From cnt=0, en=1, A=0 -> cnt=7 (Y=100), wrap=1 one cycle; then cnt=6 (Y=101), wrap=0.
REQ-031 SAT=1: count up to 7, keep en=1, A=1 for 3 more edges -> cnt stays 7, wrap=1 each of those cycles; switch A=0 -> cnt=6, wrap=0.
REQ-032 MAXVAL=5, GRAY=0: up from 0 -> 0,1,2,3,4,5,0; load with d=7 -> cnt=5; load and en both high -> load wins.
REQ-033 Counting at cnt=4 with en=1, assert reset one cycle -> cnt=0, wrap=0 next edge; deassert -> cnt=1 following edge (A=1).
REQ-034 en=0 for 4 edges with A toggling -> Y unchanged, wrap=0, tc follows A per REQ-022.
